// File: rtl/riscv_trace_pkg.sv
// Shared types and record layout for the commit-side trace recorder.
// A record is packed MSB-first as {pc, instr, wb_data, store_data, memtoreg, ena_wr, ena_rd}.
package riscv_trace_pkg;

    typedef enum logic [1:0] {
        MODE_ALL  = 2'b00,
        MODE_MEM  = 2'b01,
        MODE_TRIG = 2'b10
    } trace_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        DONE    = 2'b11
    } trace_state_t;

    function automatic int unsigned REC_W(input int unsigned data_w);
        return 4 * data_w + 3;
    endfunction

    localparam int unsigned OFF_ENA_RD   = 0;
    localparam int unsigned OFF_ENA_WR   = 1;
    localparam int unsigned OFF_MEMTOREG = 2;
    localparam int unsigned OFF_STORE    = 3;

    function automatic int unsigned off_wb(input int unsigned data_w);
        return OFF_STORE + data_w;
    endfunction

    function automatic int unsigned off_instr(input int unsigned data_w);
        return OFF_STORE + 2 * data_w;
    endfunction

    function automatic int unsigned off_pc(input int unsigned data_w);
        return OFF_STORE + 3 * data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record store with occupancy count, sticky overflow and optional overwrite-oldest.
// rd_data is a combinational read of the oldest slot.
module trace_fifo
    import riscv_trace_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned RW     = REC_W(DATA_W),
    localparam int unsigned CW     = ADDR_W + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic          wrap,
    input  logic [RW-1:0] wr_data,
    output logic [RW-1:0] rd_data,
    output logic          valid,
    output logic          full,
    output logic          overflow,
    output logic [CW-1:0] count
);

    logic [RW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              overflow_q;

    logic do_pop, accept, overwrite, drop, do_write;

    always_comb begin
        valid     = (count_q != '0);
        full      = (count_q == CW'(DEPTH));
        do_pop    = pop & valid;
        // When full, a same-cycle pop frees a slot only if overwriting is allowed.
        accept    = push & (~full | (wrap & do_pop));
        overwrite = push & full & wrap & ~do_pop;
        drop      = push & full & ~wrap;
        do_write  = accept | overwrite;
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (do_pop || overwrite) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            count_q <= count_q + CW'(accept) - CW'(do_pop);
            if (overwrite || drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign rd_data  = mem[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-side trace recorder: capture FSM, sample qualifier and record packing
// in front of a circular record store drained through a valid/ready port.
module riscv_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned RW     = REC_W(DATA_W)
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic [DATA_W-1:0] PC_addr,
    input  logic [DATA_W-1:0] instr_rom,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] dout_ram,
    input  logic [DATA_W-1:0] dataram_wr_sig,
    input  logic              MemtoReg_mux,
    input  logic              ena_wr_sig,
    input  logic              ena_rd_sig,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_wrap,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic              arm,
    input  logic              disarm,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [RW-1:0]     rd_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [1:0]        state
);

    trace_state_t      state_q, state_d;
    trace_mode_t       mode_eff;
    logic              push, pop, full, qualified;
    logic [DATA_W-1:0] wb_data;
    logic [RW-1:0]     record;

    always_comb begin
        mode_eff  = (cfg_mode == 2'b11) ? MODE_ALL : trace_mode_t'(cfg_mode);
        qualified = (mode_eff == MODE_MEM) ? (ena_wr_sig | ena_rd_sig) : 1'b1;
        wb_data   = MemtoReg_mux ? dout_ram : alu_result;
        record    = {PC_addr, instr_rom, wb_data, dataram_wr_sig,
                     MemtoReg_mux, ena_wr_sig, ena_rd_sig};
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        if (arm) begin
            state_d = ARMED;
        end else if (disarm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ARMED: begin
                    if (mode_eff != MODE_TRIG) begin
                        state_d = CAPTURE;
                    end else if (PC_addr == trig_pc) begin
                        // The trigger cycle itself becomes the first record.
                        state_d = CAPTURE;
                        push    = 1'b1;
                    end
                end
                CAPTURE: begin
                    push = qualified;
                    if (qualified && full && !cfg_wrap) begin
                        state_d = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // arm flushes the store, so a coincident pop must not be seen as consumed.
    assign pop   = rd_valid & rd_ready & ~arm;
    assign state = state_q;

    trace_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (reloj),
        .rst      (reset),
        .flush    (arm),
        .push     (push),
        .pop      (pop),
        .wrap     (cfg_wrap),
        .wr_data  (record),
        .rd_data  (rd_data),
        .valid    (rd_valid),
        .full     (full),
        .overflow (overflow),
        .count    (count)
    );

endmodule
